// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared definitions for the up/down sweep controller: state encoding and
// default widths for the counter and the completed-sweep tally.
package updown_sweep_ctrl_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_SWEEP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RISE  = 3'd2,
    ST_FALL  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for an external up/down counter: clear, rise to the
// upper limit, dwell, fall to the lower limit, dwell, then finish or repeat.
module updown_sweep_ctrl
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SWEEP_W = DEF_SWEEP_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [WIDTH-1:0]   count,
  output logic               cnt_clr,
  output logic               cnt_en,
  output logic               cnt_up_down,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [SWEEP_W-1:0] sweeps
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic               mode_q;
  logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
  logic               cfg_err_q, cfg_err_d;
  logic               latch_cfg;

  function automatic logic [SWEEP_W-1:0] sat_inc(input logic [SWEEP_W-1:0] v);
    return (&v) ? v : v + SWEEP_W'(1);
  endfunction

  // Outputs depend on the live count so a step is never issued past a limit,
  // even when the counter was disturbed out of range.
  always_comb begin
    state_d     = state_q;
    sweeps_d    = sweeps_q;
    cfg_err_d   = 1'b0;
    latch_cfg   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    cnt_up_down = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (lo_lim < hi_lim) begin
            latch_cfg = 1'b1;
            sweeps_d  = '0;
            state_d   = ST_CLEAR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        cnt_clr = 1'b1;
        state_d = stop ? ST_IDLE : ST_RISE;
      end
      ST_RISE: begin
        cnt_up_down = 1'b1;
        if (stop)               state_d = ST_IDLE;
        else if (count >= hi_q) state_d = ST_FALL;
        else                    cnt_en  = 1'b1;
      end
      ST_FALL: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (count <= lo_q) begin
          sweeps_d = sat_inc(sweeps_q);
          state_d  = mode_q ? ST_RISE : ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      mode_q    <= 1'b0;
      sweeps_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweeps_q  <= sweeps_d;
      cfg_err_q <= cfg_err_d;
      if (latch_cfg) begin
        lo_q   <= lo_lim;
        hi_q   <= hi_lim;
        mode_q <= mode;
      end
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign cfg_err = cfg_err_q;
  assign sweeps  = sweeps_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl driving a behavioural up/down counter; expected
// per-cycle outputs come from a sweep-trajectory plan built on each start.
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [3:0] lo_lim = '0, hi_lim = '0;
  logic [3:0] count = '0;
  logic       cnt_clr, cnt_en, cnt_up_down, busy, done, cfg_err;
  logic [7:0] sweeps;

  int checks = 0;
  int errors = 0;

  updown_sweep_ctrl #(.WIDTH(4), .SWEEP_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .count(count),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_up_down(cnt_up_down),
    .busy(busy), .done(done), .cfg_err(cfg_err), .sweeps(sweeps)
  );

  always #5 clk = ~clk;

  // The counter the controller steers.
  always @(posedge clk) begin
    if (cnt_clr)     count <= '0;
    else if (cnt_en) count <= cnt_up_down ? count + 4'd1 : count - 4'd1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at %0t: timeout waiting for DUT", nm, $time);
  endtask

  // Model: one entry per expected cycle of an active sweep.
  typedef struct {
    bit         cchk;
    logic       clr, en, ud, dn;
    logic [3:0] cnt;
    logic [7:0] sw;
  } exp_t;

  exp_t q[$];
  exp_t ce;
  logic [7:0] m_sw = '0;
  logic       exp_err = 1'b0;

  function automatic void push(bit cc, logic clr, logic en, logic ud, logic dn,
                               int c, int s);
    exp_t e;
    e.cchk = cc; e.clr = clr; e.en = en; e.ud = ud; e.dn = dn;
    e.cnt = 4'(c); e.sw = 8'(s);
    q.push_back(e);
  endfunction

  function automatic void plan(int lo, int hi, bit m);
    int c = 0;
    int s = 0;
    bit go = 1;
    push(0, 1, 0, 0, 0, 0, 0);
    while (go) begin
      while (c < hi) begin push(1, 0, 1, 1, 0, c, s); c++; end
      push(1, 0, 0, 1, 0, c, s);
      while (c > lo) begin push(1, 0, 1, 0, 0, c, s); c--; end
      push(1, 0, 0, 0, 0, c, s);
      s = (s >= 255) ? 255 : s + 1;
      if (!m) begin
        push(1, 0, 0, 0, 1, c, s);
        go = 0;
      end else if (q.size() > 200) begin
        go = 0;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_en", cnt_en, 0);
      chk("rst_clr", cnt_clr, 0);
      chk("rst_sweeps", sweeps, 0);
      q.delete();
      m_sw = '0;
      exp_err = 1'b0;
    end else begin
      chk("cfg_err", cfg_err, exp_err);
      exp_err = 1'b0;
      if (q.size() == 0) begin
        chk("idle_clr", cnt_clr, 0);
        chk("idle_en", cnt_en, 0);
        chk("idle_ud", cnt_up_down, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_sweeps", sweeps, m_sw);
        if (start) begin
          if (lo_lim < hi_lim) plan(int'(lo_lim), int'(hi_lim), mode);
          else                 exp_err = 1'b1;
        end
      end else begin
        ce = q.pop_front();
        if (stop && !ce.dn) begin
          ce.en = 1'b0;
          q.delete();
        end
        chk("clr", cnt_clr, ce.clr);
        chk("en", cnt_en, ce.en);
        chk("ud", cnt_up_down, ce.ud);
        chk("busy", busy, 1);
        chk("done", done, ce.dn);
        chk("sweeps", sweeps, ce.sw);
        if (ce.cchk) chk("count", count, ce.cnt);
        m_sw = ce.sw;
      end
    end
  end

  task automatic pulse_start(input logic m, input logic [3:0] lo, input logic [3:0] hi);
    @(posedge clk); #1;
    start = 1'b1; mode = m; lo_lim = lo; hi_lim = hi;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic single_sweep(input string tag);
    int tr[11];
    tr = '{0, 1, 2, 3, 4, 5, 5, 4, 3, 2, 2};
    pulse_start(1'b0, 4'd2, 4'd5);
    chk({tag, "_clr1"}, cnt_clr, 1);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      chk({tag, "_trace"}, count, tr[i]);
    end
    chk({tag, "_done"}, done, 1);
    @(posedge clk); #1;
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_done_end"}, done, 0);
    chk({tag, "_sweeps"}, sweeps, 1);
  endtask

  initial begin
    int tr2[12];
    bit found;
    tr2 = '{0, 1, 2, 3, 3, 2, 1, 1, 2, 3, 3, 2};

    #2;
    chk("por_busy", busy, 0);
    chk("por_en", cnt_en, 0);
    chk("por_sweeps", sweeps, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 1: single sweep lo=2 hi=5
    single_sweep("s1");

    // 2: continuous lo=1 hi=3, stopped after 20 cycles
    pulse_start(1'b1, 4'd1, 4'd3);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("s2_trace", count, tr2[i]);
    end
    repeat (8) begin @(posedge clk); #1; end
    chk("s2_sweeps_run", sweeps, 3);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("s2_busy_stop", busy, 0);
    chk("s2_sweeps_kept", sweeps, 3);
    chk("s2_count_frozen", count, 1);

    // 3: stop during rise at count 4
    pulse_start(1'b0, 4'd2, 4'd6);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (count == 4'd4) found = 1;
    end
    if (!found) timeout_fail("s3_reach4");
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("s3_busy", busy, 0);
    chk("s3_count_4or5", int'(count == 4'd4 || count == 4'd5), 1);
    chk("s3_sweeps", sweeps, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("s3_count_hold", count, 4);

    // 4: invalid limits rejected
    pulse_start(1'b0, 4'd5, 4'd5);
    chk("s4a_err", cfg_err, 1);
    chk("s4a_busy", busy, 0);
    @(posedge clk); #1;
    chk("s4a_err_gone", cfg_err, 0);
    pulse_start(1'b1, 4'd7, 4'd3);
    chk("s4b_err", cfg_err, 1);
    chk("s4b_busy", busy, 0);
    @(posedge clk); #1;
    chk("s4b_err_gone", cfg_err, 0);

    // 5: async reset in the middle of the fall, then a fresh sweep
    pulse_start(1'b0, 4'd2, 4'd5);
    repeat (8) begin @(posedge clk); #1; end
    chk("s5_pre_count", count, 4);
    chk("s5_pre_dir", cnt_up_down, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s5_busy", busy, 0);
    chk("s5_en", cnt_en, 0);
    chk("s5_sweeps", sweeps, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    single_sweep("s5");

    // 6: limit changes and restart while busy are ignored; hi=15 turns without wrap
    pulse_start(1'b0, 4'd1, 4'd15);
    pulse_start(1'b1, 4'd0, 4'd3);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (count == 4'd15) found = 1;
    end
    if (!found) timeout_fail("s6_reach15");
    chk("s6_peak_en", cnt_en, 0);
    chk("s6_peak_dir", cnt_up_down, 1);
    @(posedge clk); #1;
    chk("s6_dwell_cnt", count, 15);
    chk("s6_fall_dir", cnt_up_down, 0);
    @(posedge clk); #1;
    chk("s6_fall_cnt", count, 14);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (!busy) found = 1;
    end
    if (!found) timeout_fail("s6_finish");
    chk("s6_sweeps", sweeps, 1);
    chk("s6_low_cnt", count, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
Sequencing controller for the up/down counter datapath (clk, up_down, count). It runs triangle sweeps between a programmable lower and upper limit: clear, count up to the upper limit, turn, count down to the lower limit. The sweep runs once or repeats continuously. It sits between the control/CSR logic and the counter, drives the counter's clear, enable and direction inputs, and watches its count output.

Parameters:
WIDTH, 4, counter width in bits.
SWEEP_W, 8, width of the completed-sweep counter.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
stop  input  1  abort request; takes effect from any active state.
mode  input  1  0 = single sweep, 1 = continuous; latched at start.
lo_lim  input  WIDTH  lower turn point; latched at start.
hi_lim  input  WIDTH  upper turn point; latched at start.
count  input  WIDTH  current counter value, fed back from the counter.
cnt_clr  output  1  synchronous clear to the counter.
cnt_en  output  1  counter step enable.
cnt_up_down  output  1  direction: 1 = up, 0 = down.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when a single-mode sweep completes.
cfg_err  output  1  one-cycle pulse when start is rejected for invalid limits.
sweeps  output  SWEEP_W  count of completed down-legs since the last accepted start.

Behaviour:
- Counter contract: on a clk edge, cnt_clr=1 sets count=0. Otherwise cnt_en=1 steps count by +1 if cnt_up_down=1, or by -1 if cnt_up_down=0.
- Reset (async, reset_n=0): state=IDLE; all outputs 0; sweeps=0; latched limits and mode = 0.
- States: IDLE, CLEAR, RISE, FALL, DONE.
- IDLE: cnt_en=0.
  - start=1 with lo_lim<hi_lim: latch lo_lim, hi_lim and mode; clear sweeps; go to CLEAR.
  - start=1 with lo_lim>=hi_lim: pulse cfg_err next cycle, stay in IDLE.
- CLEAR: cnt_clr=1 for exactly one cycle, then go to RISE.
- RISE: cnt_up_down=1.
  - cnt_en=1 while count<hi.
  - When count>=hi: cnt_en=0 (one-cycle dwell at the peak), next state FALL.
- FALL: cnt_up_down=0.
  - cnt_en=1 while count>lo.
  - When count<=lo: cnt_en=0 (dwell), sweeps increments (saturates at all-ones), next state DONE if mode=0, else RISE.
- DONE: done=1 for one cycle, then IDLE.
- Outputs are decoded from the current state and the count input (Mealy on count). This guarantees no overshoot past a limit.
- Latency: start accepted at edge N; cnt_clr high in cycle N+1; first up-step enabled in cycle N+2.
- stop has priority over every transition. From CLEAR, RISE or FALL: next state IDLE, cnt_en=0 in the stop cycle, no done pulse, sweeps retained. stop in IDLE or DONE: no effect; DONE still returns to IDLE.
- start while busy is ignored. Limit and mode inputs are ignored while busy.
- start and stop together in IDLE: start wins and stop is ignored.
- Out-of-range count (external disturbance): the >= and <= comparisons force the turn; the controller never steps further past a limit.
- lo=0 is legal. The first RISE always begins from 0 after CLEAR, so the initial leg may pass below lo.

Decomposition:
- Shared package: state encoding constants (IDLE=0, CLEAR=1, RISE=2, FALL=3, DONE=4, 3 bits) and default WIDTH/SWEEP_W.
- No sub-module needed; a single FSM plus the sweep counter.
- Benches instantiate this block alongside the existing up/down counter, extended with clear and enable inputs.

Test Plan:
1. Single sweep, lo=2, hi=5, mode=0, start pulse → cnt_clr for 1 cycle; count 0,1,2,3,4,5,5,4,3,2,2; done pulses once; sweeps=1; busy falls after done.
2. Continuous, lo=1, hi=3, mode=1, run 20 cycles → count cycles 3,3,2,1,1,2,3,3,…; sweeps increments at each lower dwell; done never asserted.
3. stop asserted while count=4 during RISE (lo=2, hi=6) → next cycle IDLE, count frozen at 4 or 5, busy=0, no done, sweeps unchanged.
4. start with lo=5, hi=5, then lo=7, hi=3 → cfg_err pulses each time; state stays IDLE; cnt_clr and cnt_en never asserted.
5. reset_n dropped mid-FALL, asynchronously between edges → outputs 0 immediately; after release, a fresh start produces the scenario-1 sequence.
6. Change lo_lim/hi_lim and pulse start during an active sweep; also hold hi=15 with WIDTH=4 → original limits honoured, extra start ignored; count reaches 15 and turns without wrapping to 0.
